// File: rtl/sort_pkg.sv
// Shared definitions for the sorting-chain controller.
//   DATA_W    : word width of the PE chain (Xin/Zin/Xout/Zout)
//   DEFAULT_N : default number of PEs in the chain
//   SENTINEL  : all-ones pad word; sorts after every real word
//   state_t   : controller FSM states
package sort_pkg;

   localparam int DATA_W    = 32;
   localparam int DEFAULT_N = 8;

   localparam logic [DATA_W-1:0] SENTINEL = '1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      PAD   = 3'd2,
      FLUSH = 3'd3,
      READ  = 3'd4,
      DRAIN = 3'd5
   } state_t;

endpackage

// File: rtl/sort_obuf2.sv
// Two-entry output buffer with registered outputs.
//   clk, reset           : clock, asynchronous active-low reset
//   push, push_data/last : write side (caller guarantees space)
//   count                : current occupancy 0..2
//   out_valid/ready/data/last : downstream valid-ready stream
module sort_obuf2
   import sort_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         push_last,
   output logic [1:0]   count,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last
);

   logic         spare_valid;
   logic [W-1:0] spare_data;
   logic         spare_last;
   logic         pop;

   assign pop   = out_valid && out_ready;
   assign count = {1'b0, out_valid} + {1'b0, spare_valid};

   // The head entry drives the outputs directly, so the presented word
   // only moves on a pop; the spare entry refills the head on a pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_last    <= 1'b0;
         spare_valid <= 1'b0;
         spare_data  <= '0;
         spare_last  <= 1'b0;
      end else if (pop) begin
         if (spare_valid) begin
            out_data    <= spare_data;
            out_last    <= spare_last;
            spare_valid <= push;
            if (push) begin
               spare_data <= push_data;
               spare_last <= push_last;
            end
         end else begin
            out_valid <= push;
            if (push) begin
               out_data <= push_data;
               out_last <= push_last;
            end
         end
      end else if (push) begin
         if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= push_data;
            out_last  <= push_last;
         end else begin
            spare_valid <= 1'b1;
            spare_data  <= push_data;
            spare_last  <= push_last;
         end
      end
   end

endmodule

// File: rtl/sort_ctrl.sv
// Controller for a systolic chain of N compare/exchange PEs.
// Loads one frame of up to N words, pads with sentinels, flushes the
// chain, then shifts the sorted words out through a 2-entry buffer.
//   clk, reset                          : clock, async active-low reset
//   in_valid/in_ready/in_data/in_last   : unsorted input frame
//   out_valid/out_ready/out_data/out_last : ascending output frame
//   pe_mode, pe_shiftRead, pe_xin, pe_zin : PE chain controls
//   pe_zout                             : chain head word after a shift
//   busy, err_ovf                       : frame active, sticky overflow
module sort_ctrl
   import sort_pkg::*;
#(
   parameter int N = DEFAULT_N,
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         pe_mode,
   output logic         pe_shiftRead,
   output logic [W-1:0] pe_xin,
   output logic [W-1:0] pe_zin,
   input  logic [W-1:0] pe_zout,
   output logic         busy,
   output logic         err_ovf
);

   localparam int            CW   = $clog2(N + 1);
   localparam logic [CW-1:0] N_C  = CW'(N);
   localparam logic [CW-1:0] N_M1 = CW'(N - 1);

   state_t        state, next_state;
   logic [CW-1:0] cnt, cnt_inc, step, rcv;
   logic          accept, frame_end;
   logic          mode_d, shift_d;
   logic [W-1:0]  xin_d;
   logic          zout_valid;
   logic [1:0]    obuf_count;
   logic          can_shift;
   logic          fwd_valid, fwd_last;

   assign accept    = in_valid && in_ready && (state == IDLE || state == LOAD);
   assign cnt_inc   = cnt + 1'b1;
   assign frame_end = accept && (in_last || cnt_inc == N_C);

   // A shift is only issued when every word already heading for the
   // buffer, plus the new one, is guaranteed a slot.
   assign can_shift = ({1'b0, obuf_count} + {2'b00, pe_shiftRead}
                       + {2'b00, zout_valid}) < 3'd2;

   // Words past the frame length are pad sentinels and are dropped.
   assign fwd_valid = zout_valid && (rcv < cnt);
   assign fwd_last  = (rcv + 1'b1) == cnt;

   assign pe_zin = '0;

   // State register plus the registered PE/handshake outputs, which all
   // clear asynchronously so the chain sees no stray step during reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pe_mode      <= 1'b0;
         pe_shiftRead <= 1'b0;
         pe_xin       <= '0;
         in_ready     <= 1'b0;
         busy         <= 1'b0;
         zout_valid   <= 1'b0;
      end else begin
         state        <= next_state;
         pe_mode      <= mode_d;
         pe_shiftRead <= shift_d;
         pe_xin       <= xin_d;
         in_ready     <= (next_state == IDLE) || (next_state == LOAD);
         busy         <= (next_state != IDLE);
         zout_valid   <= pe_shiftRead;
      end
   end

   // Frame length, per-phase step counter, received-word index and the
   // sticky overflow flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         step    <= '0;
         rcv     <= '0;
         err_ovf <= 1'b0;
      end else begin
         if (accept) begin
            cnt <= cnt_inc;
         end else if (state == DRAIN && next_state == IDLE) begin
            cnt <= '0;
         end
         if (accept && cnt_inc == N_C && !in_last) begin
            err_ovf <= 1'b1;
         end
         if (state != next_state) begin
            step <= '0;
         end else if (state == PAD || state == FLUSH || shift_d) begin
            step <= step + 1'b1;
         end
         if (state == IDLE) begin
            rcv <= '0;
         end else if (zout_valid) begin
            rcv <= rcv + 1'b1;
         end
      end
   end

   // Next-state logic. A full frame needs no padding and goes straight
   // to FLUSH; DRAIN waits for the last shifted word to leave the buffer.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE, LOAD: begin
            if (frame_end) begin
               next_state = (cnt_inc == N_C) ? FLUSH : PAD;
            end else if (accept) begin
               next_state = LOAD;
            end
         end
         PAD: begin
            if (cnt + step == N_M1) begin
               next_state = FLUSH;
            end
         end
         FLUSH: begin
            if (step == N_M1) begin
               next_state = READ;
            end
         end
         READ: begin
            if (can_shift && step == N_M1) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (!pe_shiftRead && !zout_valid && obuf_count == 2'd0) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output decode: one sort step per accepted beat, one sentinel step
   // per PAD/FLUSH cycle, and throttled shifts in READ.
   always_comb begin
      mode_d  = 1'b0;
      shift_d = 1'b0;
      xin_d   = pe_xin;
      unique case (state)
         IDLE, LOAD: begin
            if (accept) begin
               mode_d = 1'b1;
               xin_d  = in_data;
            end
         end
         PAD, FLUSH: begin
            mode_d = 1'b1;
            xin_d  = '1;
         end
         READ: begin
            shift_d = can_shift;
         end
         default: begin
         end
      endcase
   end

   sort_obuf2 #(
      .W (W)
   ) u_obuf (
      .clk       (clk),
      .reset     (reset),
      .push      (fwd_valid),
      .push_data (pe_zout),
      .push_last (fwd_last),
      .count     (obuf_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

endmodule

// File: tb/tb_sort_ctrl.sv
// Self-checking bench for sort_ctrl with a behavioural PE chain.
// Expected output comes from splitting the accepted input stream into
// frames and sorting each frame with a queue sort.
module tb_sort_ctrl;
   import sort_pkg::*;

   localparam int N = 8;
   localparam int W = DATA_W;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         pe_mode, pe_shiftRead;
   logic [W-1:0] pe_xin, pe_zin, pe_zout;
   logic         busy, err_ovf;

   always #5 clk = ~clk;

   sort_ctrl #(.N(N), .W(W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .pe_mode(pe_mode), .pe_shiftRead(pe_shiftRead), .pe_xin(pe_xin), .pe_zin(pe_zin),
      .pe_zout(pe_zout), .busy(busy), .err_ovf(err_ovf)
   );

   // Behavioural PE chain: each cell keeps the smaller word and passes
   // the larger one on a registered link; an empty cell takes whatever
   // arrives. A shift moves cells toward the head and empties the tail.
   logic [W-1:0] pe_val [N];
   logic         pe_full [N];
   logic [W-1:0] pe_xo [N];
   logic         pe_xo_v [N];
   logic [W-1:0] x_in [N];
   logic         xv_in [N];
   logic [W-1:0] zout_q;

   assign pe_zout = zout_q;

   always_comb begin
      x_in[0]  = pe_xin;
      xv_in[0] = 1'b1;
      for (int i = 1; i < N; i++) begin
         x_in[i]  = pe_xo[i-1];
         xv_in[i] = pe_xo_v[i-1];
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            pe_val[i]  <= '0;
            pe_full[i] <= 1'b0;
            pe_xo[i]   <= '0;
            pe_xo_v[i] <= 1'b0;
         end
         zout_q <= '0;
      end else if (pe_mode) begin
         for (int i = 0; i < N; i++) begin
            if (!xv_in[i]) begin
               pe_xo_v[i] <= 1'b0;
            end else if (!pe_full[i]) begin
               pe_full[i] <= 1'b1;
               pe_val[i]  <= x_in[i];
               pe_xo_v[i] <= 1'b0;
            end else begin
               pe_val[i]  <= (x_in[i] < pe_val[i]) ? x_in[i] : pe_val[i];
               pe_xo[i]   <= (x_in[i] < pe_val[i]) ? pe_val[i] : x_in[i];
               pe_xo_v[i] <= 1'b1;
            end
         end
      end else if (pe_shiftRead) begin
         zout_q <= pe_val[0];
         for (int i = 0; i < N - 1; i++) begin
            pe_val[i]  <= pe_val[i+1];
            pe_full[i] <= pe_full[i+1];
         end
         pe_val[N-1]  <= pe_zin;
         pe_full[N-1] <= 1'b0;
      end
   end

   // Bench state and scoreboard
   logic [W-1:0] src_data[$];
   logic         src_last[$];
   logic [W-1:0] exp_data[$];
   logic         exp_last[$];
   logic [W-1:0] frame_q[$];
   logic         exp_ovf = 1'b0;
   logic         frame_closed = 1'b0;
   logic         prev_busy = 1'b0;
   logic         stall_prev = 1'b0;
   logic [W-1:0] stall_data = '0;
   logic         stall_last = 1'b0;
   logic [3:0]   ready_pat = 4'b1001;
   int errors = 0, checks = 0;
   int ready_mode = 0, gap_pct = 0, cyc = 0, out_seen = 0;
   int mode_pulses = 0, shift_pulses = 0;
   int hold_viol = 0, excl_viol = 0, ready_viol = 0;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [W-1:0] d, input logic l);
      src_data.push_back(d);
      src_last.push_back(l);
   endtask

   // Reference model: a frame closes on in_last or on its Nth word.
   task automatic modelBeat(input logic [W-1:0] d, input logic l);
      frame_q.push_back(d);
      if (l || frame_q.size() == N) begin
         if (!l) exp_ovf = 1'b1;
         frame_q.sort();
         foreach (frame_q[i]) begin
            exp_data.push_back(frame_q[i]);
            exp_last.push_back(i == frame_q.size() - 1);
         end
         frame_q.delete();
         frame_closed = 1'b1;
      end
   endtask

   task automatic stepCycle();
      logic acc;
      @(negedge clk);
      cyc++;
      if (pe_mode && pe_shiftRead) excl_viol++;
      if (frame_closed && in_ready) ready_viol++;
      if (pe_mode) mode_pulses++;
      if (pe_shiftRead) shift_pulses++;
      if (stall_prev && (!out_valid || out_data !== stall_data || out_last !== stall_last)) hold_viol++;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
      if (out_valid && out_ready) begin
         checkOutput("out_expected", exp_data.size() > 0, 1);
         if (exp_data.size() > 0) begin
            checkOutput("out_data", out_data, exp_data.pop_front());
            checkOutput("out_last", out_last, exp_last.pop_front());
         end
         out_seen++;
         if (out_last) frame_closed = 1'b0;
      end
      if (prev_busy && !busy) begin
         checkOutput("mode_pulses", mode_pulses, 2 * N);
         checkOutput("shift_pulses", shift_pulses, N);
         mode_pulses  = 0;
         shift_pulses = 0;
      end
      prev_busy = busy;
      acc = in_valid && in_ready;
      if (acc) begin
         modelBeat(in_data, in_last);
         void'(src_data.pop_front());
         void'(src_last.pop_front());
      end
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
         if (src_data.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
            in_valid = 1'b1;
            in_data  = src_data[0];
            in_last  = src_last[0];
         end else begin
            in_valid = 1'b0;
         end
      end
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = ready_pat[cyc % 4];
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic runUntilDone(input int budget);
      int n = 0;
      while ((src_data.size() != 0 || exp_data.size() != 0 || busy || in_valid) && n < budget) begin
         stepCycle();
         n++;
      end
      checkOutput("drain_timeout", n >= budget, 0);
      checkOutput("err_ovf", err_ovf, exp_ovf);
   endtask

   task automatic clearBench();
      src_data.delete(); src_last.delete();
      exp_data.delete(); exp_last.delete();
      frame_q.delete();
      exp_ovf = 1'b0; frame_closed = 1'b0; prev_busy = 1'b0; stall_prev = 1'b0;
      mode_pulses = 0; shift_pulses = 0;
      in_valid = 1'b0;
   endtask

   initial begin
      int v_a [8] = '{10, 24, 6, 7, 3, 1, 100, 6};
      int v_b [4] = '{9, 6, 5, 3};
      int n;

      // Reset: every output low while reset is held
      #3 reset = 1'b0;
      #1;
      checkOutput("rst_ctrl", {pe_mode, pe_shiftRead, out_valid, out_last, busy, err_ovf, in_ready}, 0);
      checkOutput("rst_pe_xin", pe_xin, 0);
      checkOutput("rst_pe_zin", pe_zin, 0);
      checkOutput("rst_out_data", out_data, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle_in_ready", in_ready, 1);
      checkOutput("idle_busy", busy, 0);

      // Full frame, always ready
      for (int i = 0; i < 8; i++) applyStimulus(W'(v_a[i]), i == 7);
      runUntilDone(2000);

      // Short frame needing padding
      for (int i = 0; i < 4; i++) applyStimulus(W'(v_b[i]), i == 3);
      runUntilDone(2000);

      // Full frame with a 1,0,0,1 ready pattern
      ready_mode = 1;
      for (int i = 0; i < 8; i++) applyStimulus(W'(v_a[i]), i == 7);
      runUntilDone(2000);

      // Overflow: nine beats, the ninth starts a single-word frame
      ready_mode = 0;
      for (int i = 1; i <= 9; i++) applyStimulus(W'(i), i == 9);
      runUntilDone(2000);

      // Random frames with input gaps and random backpressure
      ready_mode = 2;
      gap_pct = 30;
      for (int f = 0; f < 40; f++) begin
         int len = $urandom_range(1, N + 3);
         for (int i = 0; i < len; i++) begin
            int r = $urandom_range(0, 9);
            logic [W-1:0] d;
            if (r < 5) d = W'($urandom_range(0, 7));
            else if (r == 9) d = SENTINEL;
            else d = W'($urandom);
            applyStimulus(d, i == len - 1);
         end
      end
      runUntilDone(20000);

      // Reset during READ after three outputs, then a fresh frame
      ready_mode = 1;
      gap_pct = 0;
      out_seen = 0;
      for (int i = 0; i < 8; i++) applyStimulus(W'(v_a[i]), i == 7);
      n = 0;
      while (out_seen < 3 && n < 500) begin
         stepCycle();
         n++;
      end
      checkOutput("pre_reset_outs", out_seen, 3);
      #2 reset = 1'b0;
      #1;
      checkOutput("midrst_ctrl", {pe_mode, pe_shiftRead, out_valid, out_last, busy, err_ovf, in_ready}, 0);
      checkOutput("midrst_pe_xin", pe_xin, 0);
      clearBench();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      ready_mode = 0;
      applyStimulus(W'(5), 1'b0);
      applyStimulus(W'(2), 1'b1);
      runUntilDone(2000);

      checkOutput("mode_shift_excl", excl_viol, 0);
      checkOutput("in_ready_closed", ready_viol, 0);
      checkOutput("stall_hold", hold_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
